// File: rtl/axis_demux_pkt_fifo.sv
// Packet-aware AXI-Stream 1:NUM_CH demultiplexer with a DEPTH-entry FIFO on every output channel.
// Optional macro AXIS_DEMUX_OOR_DROP_EN: drop out-of-range packets and count them on drop_cnt_o.
module axis_demux_pkt_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 1 << ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  aclk_i,
  input  logic                  aresetn_i,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  input  logic [ADDR_WIDTH-1:0] taddr_i,
  input  logic                  tlast_i,
  input  logic                  tvalid_i,
  output logic                  tready_o,
  output logic [DATA_WIDTH-1:0] tdata_o [0:NUM_CH-1],
  output logic [NUM_CH-1:0]     tlast_o,
  output logic [NUM_CH-1:0]     tvalid_o,
  input  logic [NUM_CH-1:0]     tready_i,
  output logic                  pkt_active_o
`ifdef AXIS_DEMUX_OOR_DROP_EN
  ,
  output logic [15:0]           drop_cnt_o
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] NUM_CH_A = (ADDR_WIDTH+1)'(NUM_CH);
  localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [PTR_W:0]      DEPTH_C  = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   addr_q;
  logic              drop_q;
  logic              latch_en;
  logic              addr_oor;
  logic [CH_W-1:0]   route;
  logic              route_drop;
  logic [NUM_CH-1:0] full;
  logic              accept;
  logic              push_en;

  assign addr_oor = ({1'b0, taddr_i} >= NUM_CH_A);

  // Outside a packet the live address picks the channel; inside, the latched one does.
  always_comb begin
    route      = addr_q;
    route_drop = drop_q;
    if (state_q == IDLE) begin
      route = addr_oor ? LAST_CH : taddr_i[CH_W-1:0];
`ifdef AXIS_DEMUX_OOR_DROP_EN
      route_drop = addr_oor;
`else
      route_drop = 1'b0;
`endif
    end
  end

  // Ready looks only at registered occupancy, so no path exists from any tready_i.
  assign tready_o = aresetn_i & (route_drop | ~full[route]);
  assign accept   = tvalid_i & tready_o;
  assign push_en  = accept & ~route_drop;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    pkt_active_o = (state_q == IN_PKT);
    case (state_q)
      IDLE: begin
        if (accept && !tlast_i) begin
          state_d  = IN_PKT;
          latch_en = 1'b1;
        end
      end
      IN_PKT: begin
        if (accept && tlast_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      addr_q <= '0;
      drop_q <= 1'b0;
    end else if (latch_en) begin
      addr_q <= route;
      drop_q <= route_drop;
    end
  end

`ifdef AXIS_DEMUX_OOR_DROP_EN
  // A dropped packet is counted once, on its first beat, and the counter saturates.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      drop_cnt_o <= '0;
    end else if (accept && (state_q == IDLE) && route_drop && (drop_cnt_o != 16'hFFFF)) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [DATA_WIDTH:0] hold_q;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;
    logic                push;
    logic                pop;

    assign push        = push_en && (route == CH_W'(g));
    assign pop         = tvalid_o[g] & tready_i[g];
    assign tvalid_o[g] = (count != '0);
    assign full[g]     = (count == DEPTH_C);

    // When empty the outputs show the last popped beat, which keeps them defined.
    assign tdata_o[g] = tvalid_o[g] ? mem[rd_ptr][DATA_WIDTH-1:0] : hold_q[DATA_WIDTH-1:0];
    assign tlast_o[g] = tvalid_o[g] ? mem[rd_ptr][DATA_WIDTH]     : hold_q[DATA_WIDTH];

    always_ff @(posedge aclk_i) begin
      if (push) begin
        mem[wr_ptr] <= {tlast_i, tdata_i};
      end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        hold_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          hold_q <= mem[rd_ptr];
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_demux_pkt_fifo.sv
// Self-checking bench for axis_demux_pkt_fifo (NUM_CH=10, DEPTH=4) with a queue-based reference model.
// Builds with or without AXIS_DEMUX_OOR_DROP_EN.
module tb_axis_demux_pkt_fifo;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int NCH = 10;
  localparam int DEP = 4;

  logic           aclk_i    = 1'b0;
  logic           aresetn_i = 1'b0;
  logic [DW-1:0]  tdata_i;
  logic [AW-1:0]  taddr_i;
  logic           tlast_i;
  logic           tvalid_i;
  logic           tready_o;
  logic [DW-1:0]  tdata_o [0:NCH-1];
  logic [NCH-1:0] tlast_o;
  logic [NCH-1:0] tvalid_o;
  logic [NCH-1:0] tready_i;
  logic           pkt_active_o;
`ifdef AXIS_DEMUX_OOR_DROP_EN
  logic [15:0]    drop_cnt_o;
`endif

  int tests_run;
  int tests_failed;

  // Reference model: one queue of {last,data} per channel plus packet tracking.
  logic [DW:0] mq [NCH][$];
  logic [DW:0] mhold [NCH];
  bit          m_in_pkt;
  int          m_route;
  bit          m_drop;
  int          m_drop_cnt;

  axis_demux_pkt_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_CH    (NCH),
    .DEPTH     (DEP)
  ) dut (
    .aclk_i      (aclk_i),
    .aresetn_i   (aresetn_i),
    .tdata_i     (tdata_i),
    .taddr_i     (taddr_i),
    .tlast_i     (tlast_i),
    .tvalid_i    (tvalid_i),
    .tready_o    (tready_o),
    .tdata_o     (tdata_o),
    .tlast_o     (tlast_o),
    .tvalid_o    (tvalid_o),
    .tready_i    (tready_i),
    .pkt_active_o(pkt_active_o)
`ifdef AXIS_DEMUX_OOR_DROP_EN
    ,
    .drop_cnt_o  (drop_cnt_o)
`endif
  );

  always #5 aclk_i = ~aclk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      mhold[c] = '0;
    end
    m_in_pkt   = 0;
    m_route    = 0;
    m_drop     = 0;
    m_drop_cnt = 0;
  endtask

  function automatic void model_route(output int ch, output bit drop);
    if (m_in_pkt) begin
      ch   = m_route;
      drop = m_drop;
    end else begin
      ch = (int'(taddr_i) >= NCH) ? NCH - 1 : int'(taddr_i);
`ifdef AXIS_DEMUX_OOR_DROP_EN
      drop = (int'(taddr_i) >= NCH);
`else
      drop = 1'b0;
`endif
    end
  endfunction

  function automatic bit model_ready();
    int ch;
    bit drop;
    model_route(ch, drop);
    return drop || (mq[ch].size() < DEP);
  endfunction

  task automatic applyStimulus(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit l);
    tvalid_i = v;
    taddr_i  = a;
    tdata_i  = d;
    tlast_i  = l;
  endtask

  // Advances one clock edge; model and DUT see the same inputs, then we park on the falling edge.
  task automatic cycle();
    int          ch;
    bit          drop;
    bit          acc;
    bit          tl;
    logic [DW:0] beat;
    bit          popv [NCH];
    model_route(ch, drop);
    acc  = tvalid_i && model_ready();
    tl   = tlast_i;
    beat = {tlast_i, tdata_i};
    for (int c = 0; c < NCH; c++) popv[c] = (mq[c].size() != 0) && tready_i[c];
    @(posedge aclk_i);
    for (int c = 0; c < NCH; c++) if (popv[c]) mhold[c] = mq[c].pop_front();
    if (acc && !drop) mq[ch].push_back(beat);
    if (acc) begin
      if (!m_in_pkt) begin
        if (drop && m_drop_cnt < 65535) m_drop_cnt++;
        if (!tl) begin
          m_in_pkt = 1;
          m_route  = ch;
          m_drop   = drop;
        end
      end else if (tl) begin
        m_in_pkt = 0;
      end
    end
    @(negedge aclk_i);
  endtask

  task automatic test_reset();
    aresetn_i = 1'b0;
    applyStimulus(0, '0, '0, 0);
    tready_i = '1;
    model_reset();
    #1;
    tests_run++;
    if (tready_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_tready_low: got %b expected 0", tready_o);
    end
    repeat (2) @(negedge aclk_i);
    aresetn_i = 1'b1;
    #1;
    tests_run++;
    if (tvalid_o !== '0 || tlast_o !== '0 || pkt_active_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: tvalid %b tlast %b active %b expected all 0", tvalid_o, tlast_o, pkt_active_o);
    end
    for (int c = 0; c < NCH; c++) begin
      tests_run++;
      if (tdata_o[c] !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_tdata ch%0d: got %h expected 0", c, tdata_o[c]);
      end
    end
    tests_run++;
    if (tready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_tready_after: got %b expected 1", tready_o);
    end
`ifdef AXIS_DEMUX_OOR_DROP_EN
    tests_run++;
    if (drop_cnt_o !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt_o);
    end
`endif
  endtask

  task automatic test_single_beat();
    logic [NCH-1:0] ev;
    tready_i = '1;
    applyStimulus(1, 4'd3, 16'hA5A5, 1);
    #1;
    tests_run++;
    if (tready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_tready: got %b expected 1", tready_o);
    end
    cycle();
    applyStimulus(0, '0, '0, 0);
    ev = '0;
    ev[3] = 1'b1;
    tests_run++;
    if (tvalid_o !== ev || tdata_o[3] !== 16'hA5A5 || tlast_o[3] !== 1'b1 || pkt_active_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_out: tvalid %b data %h last %b active %b expected %b A5A5 1 0",
               tvalid_o, tdata_o[3], tlast_o[3], pkt_active_o, ev);
    end
    cycle();
    tests_run++;
    if (tvalid_o !== '0 || tdata_o[3] !== 16'hA5A5) begin
      tests_failed++;
      $display("[TB] FAIL single_after_pop: tvalid %b data %h expected 0 A5A5", tvalid_o, tdata_o[3]);
    end
  endtask

  task automatic test_packet_route();
    int addrs [4] = '{2, 5, 7, 1};
    logic [NCH-1:0] ev;
    tready_i = '1;
    ev = '0;
    ev[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, AW'(addrs[i]), DW'(i + 1), i == 3);
      #1;
      tests_run++;
      if (tready_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL pkt_tready beat%0d: got %b expected 1", i, tready_o);
      end
      cycle();
      applyStimulus(0, '0, '0, 0);
      tests_run++;
      if (tvalid_o !== ev || tdata_o[2] !== DW'(i + 1) || tlast_o[2] !== (i == 3) || pkt_active_o !== (i < 3)) begin
        tests_failed++;
        $display("[TB] FAIL pkt_beat%0d: tvalid %b data %h last %b active %b expected %b %h %b %b",
                 i, tvalid_o, tdata_o[2], tlast_o[2], pkt_active_o, ev, DW'(i + 1), (i == 3), (i < 3));
      end
    end
    cycle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got [$];
    int sent = 0;
    bit ok;
    tready_i    = '1;
    tready_i[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 4'd1, DW'(16'h10 + sent), sent == 5);
      #1;
      tests_run++;
      if (tready_o !== (sent < 4)) begin
        tests_failed++;
        $display("[TB] FAIL bp_tready cyc%0d: got %b expected %b", k, tready_o, (sent < 4));
      end
      if (model_ready()) sent++;
      cycle();
    end
    tready_i[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (sent < 6) applyStimulus(1, 4'd1, DW'(16'h10 + sent), sent == 5);
      else applyStimulus(0, '0, '0, 0);
      #1;
      if (k == 0) begin
        tests_run++;
        if (tready_o !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL bp_full_pop_tready: got %b expected 0", tready_o);
        end
      end
      if (tvalid_o[1]) got.push_back(tdata_o[1]);
      if (tvalid_i && model_ready()) sent++;
      cycle();
      tests_run++;
      if (tvalid_o[1] !== (mq[1].size() != 0)) begin
        tests_failed++;
        $display("[TB] FAIL bp_tvalid cyc%0d: got %b expected %b", k, tvalid_o[1], (mq[1].size() != 0));
      end
    end
    ok = (got.size() == 6);
    if (ok) for (int i = 0; i < 6; i++) if (got[i] !== DW'(16'h10 + i)) ok = 0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL bp_order: got %0d beats %p expected 6 beats 10..15", got.size(), got);
    end
  endtask

  task automatic test_interleave();
    tready_i    = '1;
    tready_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 4'd0, DW'(16'h100 + i), i == 3);
      #1;
      tests_run++;
      if (tready_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL il_fill_tready beat%0d: got %b expected 1", i, tready_o);
      end
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, (i == 0) ? 4'd5 : 4'd0, DW'(16'h200 + i), i == 3);
      #1;
      tests_run++;
      if (tready_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL il_stream_stall beat%0d: got %b expected 1", i, tready_o);
      end
      cycle();
      applyStimulus(0, '0, '0, 0);
      tests_run++;
      if (tvalid_o[5] !== 1'b1 || tdata_o[5] !== DW'(16'h200 + i) || tvalid_o[0] !== 1'b1 || tdata_o[0] !== 16'h0100) begin
        tests_failed++;
        $display("[TB] FAIL il_stream beat%0d: ch5 %b/%h ch0 %b/%h expected 1/%h 1/0100",
                 i, tvalid_o[5], tdata_o[5], tvalid_o[0], tdata_o[0], DW'(16'h200 + i));
      end
    end
    tready_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (tvalid_o[0] !== 1'b1 || tdata_o[0] !== DW'(16'h100 + i)) begin
        tests_failed++;
        $display("[TB] FAIL il_drain%0d: got %b/%h expected 1/%h", i, tvalid_o[0], tdata_o[0], DW'(16'h100 + i));
      end
      cycle();
    end
    tests_run++;
    if (tvalid_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL il_empty: got %b expected 0", tvalid_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [NCH-1:0] ev;
    tready_i = '0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'd6, DW'(16'h300 + i), 0);
      #1;
      cycle();
    end
    applyStimulus(0, '0, '0, 0);
    tests_run++;
    if (tvalid_o[6] !== 1'b1 || pkt_active_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_pre: tvalid6 %b active %b expected 1 1", tvalid_o[6], pkt_active_o);
    end
    #2;
    aresetn_i = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (tvalid_o !== '0 || pkt_active_o !== 1'b0 || tdata_o[6] !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_async_reset: tvalid %b active %b data6 %h expected 0 0 0", tvalid_o, pkt_active_o, tdata_o[6]);
    end
    @(negedge aclk_i);
    aresetn_i = 1'b1;
    tready_i  = '1;
    applyStimulus(1, 4'd4, 16'h0404, 1);
    #1;
    tests_run++;
    if (tready_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_post_tready: got %b expected 1", tready_o);
    end
    cycle();
    applyStimulus(0, '0, '0, 0);
    ev = '0;
    ev[4] = 1'b1;
    tests_run++;
    if (tvalid_o !== ev || tdata_o[4] !== 16'h0404 || pkt_active_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_post_route: tvalid %b data %h active %b expected %b 0404 0", tvalid_o, tdata_o[4], pkt_active_o, ev);
    end
    cycle();
  endtask

  task automatic test_oor();
    logic [NCH-1:0] ev;
    tready_i = '1;
    ev = '0;
`ifndef AXIS_DEMUX_OOR_DROP_EN
    ev[NCH-1] = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 4'd12, DW'(16'h500 + i), i == 1);
      #1;
      tests_run++;
      if (tready_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL oor_tready beat%0d: got %b expected 1", i, tready_o);
      end
      cycle();
      applyStimulus(0, '0, '0, 0);
      tests_run++;
      if (tvalid_o !== ev) begin
        tests_failed++;
        $display("[TB] FAIL oor_tvalid beat%0d: got %b expected %b", i, tvalid_o, ev);
      end
`ifndef AXIS_DEMUX_OOR_DROP_EN
      tests_run++;
      if (tdata_o[NCH-1] !== DW'(16'h500 + i)) begin
        tests_failed++;
        $display("[TB] FAIL oor_data beat%0d: got %h expected %h", i, tdata_o[NCH-1], DW'(16'h500 + i));
      end
`endif
    end
    cycle();
`ifdef AXIS_DEMUX_OOR_DROP_EN
    tests_run++;
    if (drop_cnt_o !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL oor_drop_cnt: got %0d expected 1", drop_cnt_o);
    end
`endif
  endtask

  task automatic test_random();
    logic [NCH-1:0] ev;
    logic [NCH-1:0] el;
    logic [DW:0]    e;
    bit             data_ok;
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 2) == 0);
      tready_i = NCH'($urandom) | NCH'($urandom);
      #1;
      tests_run++;
      if (tready_o !== model_ready()) begin
        tests_failed++;
        $display("[TB] FAIL rnd_tready cyc%0d: got %b expected %b", n, tready_o, model_ready());
      end
      cycle();
      data_ok = 1;
      for (int c = 0; c < NCH; c++) begin
        e     = (mq[c].size() != 0) ? mq[c][0] : mhold[c];
        ev[c] = (mq[c].size() != 0);
        el[c] = e[DW];
        if (tdata_o[c] !== e[DW-1:0]) data_ok = 0;
      end
      tests_run++;
      if (tvalid_o !== ev || tlast_o !== el || !data_ok || pkt_active_o !== m_in_pkt) begin
        tests_failed++;
        $display("[TB] FAIL rnd_out cyc%0d: tvalid %b/%b tlast %b/%b data_ok %b active %b/%b (got/expected)",
                 n, tvalid_o, ev, tlast_o, el, data_ok, pkt_active_o, m_in_pkt);
      end
`ifdef AXIS_DEMUX_OOR_DROP_EN
      tests_run++;
      if (drop_cnt_o !== 16'(m_drop_cnt)) begin
        tests_failed++;
        $display("[TB] FAIL rnd_drop_cnt cyc%0d: got %0d expected %0d", n, drop_cnt_o, m_drop_cnt);
      end
`endif
    end
    applyStimulus(0, '0, '0, 0);
    tready_i = '1;
    repeat (DEP + 1) cycle();
    tests_run++;
    if (tvalid_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rnd_drain: got %b expected 0", tvalid_o);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_beat();
    test_packet_route();
    test_backpressure();
    test_interleave();
    test_reset_mid_packet();
    test_oor();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_demux_pkt_fifo.md
Name: axis_demux_pkt_fifo

Overview:
- Packet-aware AXI-Stream 1-to-NUM_CH demultiplexer with a DEPTH-entry FIFO on each output channel.
- Destination is taken from taddr_i on the first beat of a packet and held until the tlast beat; later beats ignore taddr_i.
- Per-channel buffering lets slow sinks stall without blocking packets bound for other channels. Full-rate streaming is possible; there is no one-beat-per-two-cycles bubble.
- Sits between a single stream source and NUM_CH independent consumers.

Parameters:
- DATA_WIDTH, 16, width of tdata_i and each tdata_o entry.
- ADDR_WIDTH, 4, width of taddr_i.
- NUM_CH, 1 << ADDR_WIDTH, number of output channels; 2 to 2^ADDR_WIDTH.
- DEPTH, 4, entries per channel FIFO; power of 2, at least 2.

Ports:
- aclk_i  input  1  system clock; all logic is on the rising edge.
- aresetn_i  input  1  asynchronous active-low reset.
- tdata_i  input  DATA_WIDTH  input beat data.
- taddr_i  input  ADDR_WIDTH  destination channel; sampled only on the first beat of a packet.
- tlast_i  input  1  last beat of the packet.
- tvalid_i  input  1  input beat valid.
- tready_o  output  1  input beat accepted when tvalid_i & tready_o.
- tdata_o  output  DATA_WIDTH x [0:NUM_CH-1]  head-of-FIFO data per channel (unpacked array).
- tlast_o  output  NUM_CH  head-of-FIFO last flag per channel.
- tvalid_o  output  NUM_CH  channel FIFO non-empty.
- tready_i  input  NUM_CH  per-channel sink ready.
- pkt_active_o  output  1  high while the block is inside a packet (state IN_PKT).

Behaviour:
- Reset (asynchronous, aresetn_i low):
  - All FIFOs empty; tvalid_o = 0, tdata_o = 0, tlast_o = 0.
  - State = IDLE, pkt_active_o = 0, latched address = 0.
  - Reset mid-packet discards all buffered beats and the partial packet.
- Route select:
  - In IDLE the route is taddr_i, mapped as described below.
  - In IN_PKT the route is the latched address.
- Out-of-range address (taddr_i >= NUM_CH, macro absent): routed to channel NUM_CH-1.
- tready_o = !full[route] & aresetn_i.
  - Depends only on registered FIFO state and the route; there is no combinational path from tready_i.
  - A full FIFO being popped in the same cycle still gives tready_o = 0.
- State machine:
  - IDLE: on an accepted beat with tlast_i = 0, latch the route and go to IN_PKT. An accepted beat with tlast_i = 1 (single-beat packet) stays in IDLE.
  - IN_PKT: on an accepted beat with tlast_i = 1, go to IDLE. taddr_i is ignored in this state.
- Push: an accepted beat writes {tdata_i, tlast_i} to FIFO[route] at the clock edge.
- Pop: FIFO[i] pops when tvalid_o[i] & tready_i[i]. Pops on different channels are independent and may occur in the same cycle.
- Same-cycle push and pop on one channel: count is unchanged, data order is preserved; allowed when the FIFO is not full.
- Latency: a beat accepted at edge k is visible on tvalid_o/tdata_o/tlast_o after edge k (cycle k+1). With the FIFO empty and tready_i held high, throughput is 1 beat per cycle.
- Head output: tdata_o[i]/tlast_o[i] show the FIFO head when tvalid_o[i] = 1 and hold the last popped value otherwise (0 after reset). They are never X.
- Pointers: rd/wr pointers of log2(DEPTH) bits wrap modulo DEPTH. Count is log2(DEPTH)+1 bits: full when count = DEPTH, empty when count = 0.
- AXI rule: once tvalid_o[i] = 1, the head stays stable until popped.

Optional Feature:
- Macro AXIS_DEMUX_OOR_DROP_EN.
- Defined:
  - A packet whose first-beat taddr_i >= NUM_CH is dropped: tready_o = 1 for every beat of that packet and nothing is pushed.
  - The state machine still tracks tlast_i.
  - Adds output drop_cnt_o [15:0], reset 0, incremented once per dropped packet on its first beat, saturating at 16'hFFFF.
- Undefined: out-of-range packets go to channel NUM_CH-1 and port drop_cnt_o is absent.

Test Plan:
- Reset, then a single beat taddr=3, tdata=16'hA5A5, tlast=1, tready_i=all 1 -> tvalid_o[3] = 1 in cycle k+1 only, tdata_o[3] = 16'hA5A5, tlast_o[3] = 1, pkt_active_o stays 0.
- 4-beat packet, taddr = 2 on beat 0, then 5, 7, 1 on later beats, data 1..4 -> all four beats appear on channel 2 in order, tlast_o[2] only on data 4, pkt_active_o = 1 from after beat 0 until after beat 3.
- DEPTH=4, tready_i[1] = 0, stream 6 beats to ch1 -> tready_o drops after the 4th accept and stays 0. Raising tready_i[1] pops data in order, 1-cycle gap; a full FIFO popped and pushed in the same cycle still shows tready_o = 0.
- Interleave: packet to ch0 with tready_i[0] = 0 fills FIFO0; the next packet to ch5 streams at 1 beat/cycle with no stall.
- Assert aresetn_i mid-packet with 3 beats buffered -> tvalid_o = 0 immediately (asynchronous), pkt_active_o = 0. The next beat is routed by its own taddr_i.
- NUM_CH=10, taddr=12, 2-beat packet -> with macro: no tvalid_o rises, drop_cnt_o = 1. Without macro: beats appear on channel 9.
